// File: rtl/otter_uart_tx_if.sv
// otter_bus: zero-wait memory-mapped bus between a primary and a responder.
interface otter_bus #(
  parameter int WIDTH = 32
);
  logic             wr;
  logic             rd;
  logic [1:0]       size;
  logic [31:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             error;
  modport primary (output wr, rd, size, addr, wdata, input rdata, error);
  modport secondary (input wr, rd, size, addr, wdata, output rdata, error);
endinterface

// File: rtl/otter_uart_tx.sv
// otter_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor.
// Define OTTER_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module otter_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868,
  parameter int DIV_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  otter_bus.secondary bus,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef OTTER_UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic [7:0]           shift_q;
  logic [2:0]           idx_q;
  logic [DIV_WIDTH-1:0] div_q, div_d, bit_q;
  logic                 ovf_q, tx_q;
  logic                 full, empty, busy, push, pop, bit_end;
  logic                 is_tx, is_st, is_bd, word, err;
  logic [31:0]          status;
  logic                 unused_bits;
  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign busy    = state_q != IDLE;
  assign is_tx   = bus.addr[3:0] == 4'h0;
  assign is_st   = bus.addr[3:0] == 4'h4;
  assign is_bd   = bus.addr[3:0] == 4'h8;
  assign word    = bus.size == 2'b10;
  // Full check uses pre-edge count, so a push is refused even if a pop happens this cycle
  assign err     = (bus.rd | bus.wr) & ((bus.rd & bus.wr) | !(is_tx | is_st | is_bd) |
                   ((is_st | is_bd) & !word) | (is_tx & (bus.rd | full)));
  assign push    = bus.wr & is_tx & !err;
  assign pop     = !busy & !empty;
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign div_d   = bus.wdata[DIV_WIDTH-1:0] == '0 ? DIV_WIDTH'(1) : bus.wdata[DIV_WIDTH-1:0];
  assign bit_end = bit_q == DIV_WIDTH'(1);
  assign status  = {16'h0, 8'(cnt_q), 3'b0, PAR_EN, empty, ovf_q, full, busy};
  assign bus.rdata = (bus.rd & !err) ? (is_st ? status : is_bd ? 32'(div_q) : '0) : '0;
  assign bus.error = err;
  assign tx  = tx_q;
  assign irq = empty & !busy;
  assign unused_bits = ^{bus.addr, bus.wdata};
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.wdata[7:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      wp_q  <= wp_q + AW'(push);
      rp_q  <= rp_q + AW'(pop);
      cnt_q <= cnt_d;
      ovf_q <= (ovf_q & !(bus.wr & is_st & !err & bus.wdata[2])) | (bus.wr & !bus.rd & is_tx & full);
      if (bus.wr & is_bd & !err) div_q <= div_d;
      // Every bit reloads its period from div_q, so divisor writes apply at the next bit boundary
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          shift_q <= mem_q[rp_q];
          bit_q   <= div_q;
          tx_q    <= 1'b0;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          idx_q   <= '0;
          bit_q   <= div_q;
          tx_q    <= shift_q[0];
        end else bit_q <= bit_q - DIV_WIDTH'(1);
        DATA: if (bit_end) begin
          bit_q <= div_q;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef OTTER_UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= ^shift_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else tx_q <= shift_q[idx_q + 3'd1];
        end else bit_q <= bit_q - DIV_WIDTH'(1);
        PARITY: if (bit_end) begin
          state_q <= STOP;
          bit_q   <= div_q;
          tx_q    <= 1'b1;
        end else bit_q <= bit_q - DIV_WIDTH'(1);
        STOP: if (bit_end) state_q <= IDLE;
          else bit_q <= bit_q - DIV_WIDTH'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otter_uart_tx.sv
// tb_otter_uart_tx: directed vector bench for otter_uart_tx register map, framing and corner cases.
module tb_otter_uart_tx;
`ifdef OTTER_UART_TX_PARITY_EN
  localparam logic [31:0] PB = 32'h10;
`else
  localparam logic [31:0] PB = 32'h0;
`endif
  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  logic clk, rst, tx, irq;
  int checks = 0, errors = 0;
  vec_t vt [16];
  logic fb [$];
  otter_bus #(.WIDTH(32)) b ();
  otter_uart_tx dut (.clk(clk), .rst(rst), .bus(b), .tx(tx), .irq(irq));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic acc(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic [31:0] m,
                     input logic ee, input string nm);
    @(negedge clk);
    b.rd = r; b.wr = w; b.size = sz; b.addr = a; b.wdata = wd;
    #1;
    chk({nm, " rdata"}, b.rdata & m, er);
    chk({nm, " error"}, 32'(b.error), 32'(ee));
    @(posedge clk); #1;
    b.rd = 1'b0; b.wr = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, bad;
    logic [7:0] d;
    vt = '{
      '{1'b1, 1'b0, 2'd2, 32'h8,  32'h0,  32'd868,     1'b0},
      '{1'b1, 1'b0, 2'd2, 32'h4,  32'h0,  32'h8 | PB,  1'b0},
      '{1'b1, 1'b0, 2'd2, 32'hC,  32'h0,  32'h0,       1'b1},
      '{1'b0, 1'b1, 2'd0, 32'h4,  32'h4,  32'h0,       1'b1},
      '{1'b1, 1'b0, 2'd2, 32'h0,  32'h0,  32'h0,       1'b1},
      '{1'b1, 1'b0, 2'd1, 32'h8,  32'h0,  32'h0,       1'b1},
      '{1'b1, 1'b1, 2'd2, 32'h4,  32'h4,  32'h0,       1'b1},
      '{1'b1, 1'b1, 2'd2, 32'h0,  32'h33, 32'h0,       1'b1},
      '{0,    1'b1, 2'd2, 32'h2,  32'hFF, 32'h0,       1'b1},
      '{1'b1, 1'b0, 2'd2, 32'h14, 32'h0,  32'h8 | PB,  1'b0},
      '{1'b0, 1'b1, 2'd2, 32'h8,  32'h0,  32'h0,       1'b0},
      '{1'b1, 1'b0, 2'd2, 32'h8,  32'h0,  32'd1,       1'b0},
      '{1'b0, 1'b1, 2'd2, 32'h8,  32'h4,  32'h0,       1'b0},
      '{1'b1, 1'b0, 2'd2, 32'h8,  32'h0,  32'd4,       1'b0},
      '{1'b1, 1'b0, 2'd2, 32'h4,  32'h0,  32'h8 | PB,  1'b0},
      '{1'b0, 1'b0, 2'd2, 32'h4,  32'h0,  32'h0,       1'b0}
    };
    rst = 1'b1;
    b.rd = 1'b0; b.wr = 1'b0; b.size = 2'd2; b.addr = '0; b.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset tx", 32'(tx), 1);
    chk("reset irq", 32'(irq), 1);
    chk("reset error", 32'(b.error), 0);
    chk("reset rdata", b.rdata, 0);
    for (int i = 0; i < 16; i++)
      acc(vt[i].rd, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].rdata, 32'hFFFF_FFFF,
          vt[i].err, $sformatf("vec%0d", i));
    d = 8'hA5;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef OTTER_UART_TX_PARITY_EN
    fb.push_back(^d);
`endif
    fb.push_back(1'b1);
    acc(1'b0, 1'b1, 2'd2, 32'h0, 32'hA5, 32'h0, 32'hFFFF_FFFF, 1'b0, "wr A5");
    chk("tx idle at write edge", 32'(tx), 1);
    chk("irq low after write", 32'(irq), 0);
    for (int i = 0; i < fb.size() * 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("frame cycle %0d", i), 32'(tx), 32'(fb[i / 4]));
    end
    @(posedge clk); #1;
    chk("irq after frame", 32'(irq), 1);
    acc(1'b0, 1'b1, 2'd2, 32'h8, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, "div=1");
    for (int i = 0; i < 10; i++)
      acc(1'b0, 1'b1, 2'd2, 32'h0, 32'(i), 32'h0, 32'hFFFF_FFFF, i == 9, $sformatf("burst%0d", i));
    acc(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 32'h807 | PB, 32'hFFFF_FFFF, 1'b0, "status overflow");
    acc(1'b0, 1'b1, 2'd2, 32'h4, 32'h4, 32'h0, 32'hFFFF_FFFF, 1'b0, "clear overflow");
    acc(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 32'h0, 32'h4, 1'b0, "overflow cleared");
    n = 0;
    while (!irq && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain irq", 32'(irq), 1);
    acc(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 32'h8 | PB, 32'hFFFF_FFFF, 1'b0, "status drained");
    acc(1'b0, 1'b1, 2'd2, 32'h8, 32'h4, 32'h0, 32'hFFFF_FFFF, 1'b0, "div=4");
    acc(1'b0, 1'b1, 2'd2, 32'h0, 32'h55, 32'h0, 32'hFFFF_FFFF, 1'b0, "wr 55");
    repeat (5) @(posedge clk);
    acc(1'b0, 1'b1, 2'd2, 32'h8, 32'h8, 32'h0, 32'hFFFF_FFFF, 1'b0, "div=8 mid bit0");
    repeat (2) @(posedge clk);
    #1 chk("bit0 end old period", 32'(tx), 1);
    @(posedge clk); #1;
    chk("bit1 start", 32'(tx), 0);
    repeat (7) @(posedge clk);
    #1 chk("bit1 new period end", 32'(tx), 0);
    @(posedge clk); #1;
    chk("bit2 start", 32'(tx), 1);
    acc(1'b1, 1'b0, 2'd2, 32'h8, 32'h0, 32'd8, 32'hFFFF_FFFF, 1'b0, "read div 8");
    for (int i = 0; i < 3; i++)
      acc(1'b0, 1'b1, 2'd2, 32'h0, 32'h11 * i, 32'h0, 32'hFFFF_FFFF, 1'b0, $sformatf("queue%0d", i));
    acc(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 32'h300, 32'hFF00, 1'b0, "count 3");
    n = 0;
    while (tx && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx low before reset", 32'(tx), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("tx after reset", 32'(tx), 1);
    chk("irq after reset", 32'(irq), 1);
    rst = 1'b0;
    acc(1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 32'h8 | PB, 32'hFFFF_FFFF, 1'b0, "status after reset");
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (!tx) bad++;
    end
    chk("no frame after reset", 32'(bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/otter_uart_tx.md
Name: otter_uart_tx

Overview:
- Memory-mapped UART transmitter on the secondary (responder) side of the otter_bus.
- The CPU or another primary writes bytes into a TX FIFO. A baud-rate serializer drives them out on a single 8N1 line.
- Status and baud-divisor registers are readable over the same bus. An upstream address decoder selects this block; it decodes only addr[3:0].

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.
- DEFAULT_DIV, 868, reset value of BAUD_DIV in clk cycles per bit (100 MHz / 115200).
- DIV_WIDTH, 16, width of BAUD_DIV and the bit-period counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high; one clock; all state on rising edge of clk.
- bus  otter_bus.secondary  WIDTH=32  otter_bus responder modport. Inputs: wr, rd, size[1:0], addr[31:0], wdata[31:0]. Outputs: rdata[31:0], error.
- tx  output  1  serial line; idles high.
- irq  output  1  high while FIFO empty and serializer idle.

Behaviour:
- Register map (offset = addr[3:0]):
  - 0x0 TXDATA: W; push wdata[7:0]; any size.
  - 0x4 STATUS: R/W, word only.
  - 0x8 BAUD_DIV: R/W, word only; value in [DIV_WIDTH-1:0].
- STATUS read layout:
  - bit0 busy (FSM != IDLE).
  - bit1 fifo_full.
  - bit2 overflow (sticky).
  - bit3 fifo_empty.
  - [15:8] fifo_count.
  - all other bits 0.
- STATUS write: wdata[2]=1 clears overflow; other bits ignored.
- Bus timing: zero-wait.
  - rdata and error are combinational from rd/wr/addr/size in the same cycle.
  - Writes commit at the rising edge where wr=1.
  - rdata=0 when rd=0.
- error=1 (same cycle) when any of the following hold:
  - offset not in {0x0,0x4,0x8};
  - size!=2'b10 to STATUS/BAUD_DIV;
  - rd to TXDATA;
  - wr to TXDATA while fifo_full.
- Errored accesses have no side effect, except that a TXDATA write while full also sets overflow. rdata=0 on any errored read.
- rd and wr both high: treated as an error, no side effect.
- FIFO full-check uses pre-edge state: a push while full is rejected even if a pop occurs in the same cycle. Push and pop in the same cycle when not full and not empty: count unchanged.
- BAUD_DIV: a write of 0 is stored as 1. A write mid-frame takes effect at the next bit boundary (counter reloads from BAUD_DIV at the start of every bit).
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If FIFO not empty: pop into shift register, load bit counter, go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[idx], LSB first. Each bit lasts BAUD_DIV cycles; after idx 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then go to IDLE. The next byte may start on the following edge: one idle cycle between back-to-back frames.
- tx is a registered output.
- Latency: a TXDATA write committed at edge k into an empty FIFO with the FSM in IDLE gives tx=0 from edge k+1. fifo_empty returns to 1 at edge k+1.
- Reset values:
  - tx=1, irq=1, FSM=IDLE;
  - FIFO empty, count 0, overflow=0;
  - BAUD_DIV=DEFAULT_DIV;
  - bit counter 0.
- Reset mid-frame: tx=1 on the next edge; queued bytes are discarded.

Optional Feature:
- OTTER_UART_TX_PARITY_EN
- Defined:
  - a PARITY state is inserted between DATA and STOP;
  - tx = even parity (XOR of the 8 data bits) for BAUD_DIV cycles;
  - STATUS bit4 reads 1 (parity present).
- Undefined: 8N1 framing only; STATUS bit4 reads 0.

Test Plan:
- Reset, then read 0x8 and 0x4 -> rdata=868 and rdata=0x00000008 (empty). tx=1, irq=1, error=0.
- Write 0x8=4, then write 0x0=0xA5 -> tx falls 1 cycle after the write edge. Line sequence is 0 followed by bits 1,0,1,0,0,1,0,1 and stop bit 1, each level held 4 cycles; 40 cycles total (44 with PARITY_EN, parity=0). irq=1 after the frame.
- BAUD_DIV=1, write 9 bytes back-to-back with no serializer progress (FIFO_DEPTH=8, first byte already popped) -> the 10th write gives error=1 and STATUS bit2=1. Write STATUS wdata=0x4 -> bit2=0.
- Read 0xC, byte write (size=00) to 0x4, rd of 0x0 -> error=1 each time, rdata=0, no state change.
- Write 0x8=0 -> read 0x8 returns 1. Write 0x8=8 mid-DATA -> the current bit keeps the old period; the following bit lasts 8 cycles.
- Assert rst during DATA with 3 bytes queued -> tx=1 next edge, STATUS=0x00000008, no further frames emitted.
